// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type encoding, default link geometry and the
// packet-framing state used by the input-port deserializer.
package noc_pkg;

    localparam int FLIT_SIZE_DEF = 2;
    localparam int PHIT_SIZE_DEF = 16;

    typedef logic [1:0] flit_type_t;

    // Same layout as the type field of the input-port flit buffer: {tail, head}.
    localparam flit_type_t FT_BODY     = 2'b00;
    localparam flit_type_t FT_HEAD     = 2'b01;
    localparam flit_type_t FT_TAIL     = 2'b10;
    localparam flit_type_t FT_HEADTAIL = 2'b11;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } frame_state_e;

    function automatic flit_type_t flit_type(input logic head, input logic tail);
        return {tail, head};
    endfunction

endpackage

// File: rtl/inport_phit_deser.sv
// Router input-port link deserializer: packs flit_size phits into a flit, holds
// it until the flit buffer accepts it, and flags packet-framing violations.
module inport_phit_deser
    import noc_pkg::*;
#(
    parameter int flit_size = FLIT_SIZE_DEF,
    parameter int phit_size = PHIT_SIZE_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [phit_size-1:0]           phit_in,
    input  logic                           phit_valid,
    input  logic                           phit_head,
    input  logic                           phit_tail,
    input  logic                           buf_full,
    output logic                           link_ready,
    output logic [flit_size*phit_size-1:0] outdata,
    output logic                           new_o,
    output logic                           out_head,
    output logic                           out_tail,
    output logic                           proto_err
);

    localparam int CNT_W  = $clog2(flit_size);
    localparam int FLIT_W = flit_size * phit_size;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(flit_size - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [FLIT_W-1:0] asm_q, asm_d;
    logic [FLIT_W-1:0] outdata_q, outdata_d;
    flit_type_t        asm_type_q, asm_type_d;
    flit_type_t        out_type_q, out_type_d;
    logic              pending_q, pending_d;
    frame_state_e      state_q;
    logic              proto_err_q;

    logic last_phit, accept, first_phit, complete;

    // A waiting flit only blocks the phit that would complete the next one.
    assign last_phit  = (cnt_q == CNT_LAST);
    assign link_ready = ~(pending_q & buf_full & last_phit);
    assign accept     = phit_valid & link_ready;
    assign first_phit = accept & (cnt_q == '0);
    assign complete   = accept & last_phit;
    assign new_o      = pending_q & ~buf_full;

    always_comb begin
        cnt_d      = cnt_q;
        asm_d      = asm_q;
        asm_type_d = asm_type_q;
        outdata_d  = outdata_q;
        out_type_d = out_type_q;
        pending_d  = pending_q;

        if (new_o) begin
            pending_d = 1'b0;
        end

        if (accept) begin
            asm_d[int'(cnt_q)*phit_size +: phit_size] = phit_in;
            cnt_d = last_phit ? '0 : cnt_q + 1'b1;
            if (first_phit) begin
                asm_type_d = flit_type(phit_head, phit_tail);
            end
        end

        // A completion on the same edge as a transfer re-arms pending with the new flit.
        if (complete) begin
            outdata_d  = asm_d;
            out_type_d = asm_type_q;
            pending_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            asm_type_q <= FT_BODY;
            outdata_q  <= '0;
            out_type_q <= FT_BODY;
            pending_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            asm_type_q <= asm_type_d;
            outdata_q  <= outdata_d;
            out_type_q <= out_type_d;
            pending_q  <= pending_d;
        end
    end

    // Partial-flit storage is only read after a full flit is collected.
    always_ff @(posedge clk) begin
        asm_q <= asm_d;
    end

    // Framing is judged on the first phit, where the type bits are valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            proto_err_q <= 1'b0;
        end else if (first_phit) begin
            case (state_q)
                IDLE: begin
                    if (!phit_head) begin
                        proto_err_q <= 1'b1;
                    end else if (!phit_tail) begin
                        state_q <= IN_PKT;
                    end
                end
                IN_PKT: begin
                    if (phit_head) begin
                        proto_err_q <= 1'b1;
                    end
                    if (phit_tail) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign outdata   = outdata_q;
    assign out_head  = (out_type_q & FT_HEAD) != FT_BODY;
    assign out_tail  = (out_type_q & FT_TAIL) != FT_BODY;
    assign proto_err = proto_err_q;

endmodule
